// File: rtl/lwe_pkg.sv
// Shared LWE constants, rounding parameters and decrypt FSM state type.
// Imported by the decrypt top and the lwe_round helper.
package lwe_pkg;

   localparam int PLAINTEXT_MODULUS  = 64;
   localparam int PLAINTEXT_WIDTH    = 6;
   localparam int CIPHERTEXT_MODULUS = 1024;
   localparam int CIPHERTEXT_WIDTH   = 10;
   localparam int DIMENSION          = 10;
   localparam int DIM_WIDTH          = 4;

   localparam int ROUND_OFFSET =
      CIPHERTEXT_MODULUS / (2 * PLAINTEXT_MODULUS);
   localparam int SHIFT = CIPHERTEXT_WIDTH - PLAINTEXT_WIDTH;

   typedef enum logic {
      ACCUM = 1'b0,
      OUT   = 1'b1
   } state_t;

endpackage

// File: rtl/decrypt_if.sv
// Ciphertext-in / plaintext-out handshake bundle for decrypt.
// master: beat source + plaintext consumer; slave: the decrypt block.
interface decrypt_if #(
   parameter int CW = lwe_pkg::CIPHERTEXT_WIDTH,
   parameter int PW = lwe_pkg::PLAINTEXT_WIDTH,
   parameter int DW = lwe_pkg::DIM_WIDTH
);

   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] ct_entry;
   logic [CW-1:0] sk_entry;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] plaintext;
   logic [DW:0]   beat_idx;

   modport master (
      output in_valid, ct_entry, sk_entry, out_ready,
      input  in_ready, out_valid, plaintext, beat_idx
   );

   modport slave (
      input  in_valid, ct_entry, sk_entry, out_ready,
      output in_ready, out_valid, plaintext, beat_idx
   );

endinterface

// File: rtl/lwe_round.sv
// Combinational LWE decode: m = ((x + q/(2p)) >> log2(q/p)) mod p.
// Ports: x (residue mod q) in, m (plaintext in [0,p)) out.
module lwe_round #(
   parameter int CW = lwe_pkg::CIPHERTEXT_WIDTH,
   parameter int PW = lwe_pkg::PLAINTEXT_WIDTH
) (
   input  logic [CW-1:0] x,
   output logic [PW-1:0] m
);

   localparam int SH = CW - PW;
   localparam logic [CW-1:0] OFF = CW'(1) << (SH - 1);

   logic [CW-1:0] sum;

   // Offset add wraps mod q, so x just below q rounds to 0.
   assign sum = x + OFF;
   assign m   = sum[CW-1:SH];

endmodule

// File: rtl/decrypt.sv
// LWE decrypt: accumulates sum(a_i*s_i) mod q over n beats, then on
// beat b decodes m = round(b - acc). Ports: clk, rst, bus (slave).
module decrypt
   import lwe_pkg::*;
#(
   parameter int CW = CIPHERTEXT_WIDTH,
   parameter int PW = PLAINTEXT_WIDTH,
   parameter int N  = DIMENSION,
   parameter int DW = DIM_WIDTH
) (
   input logic      clk,
   input logic      rst,
   decrypt_if.slave bus
);

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   acc;
   logic [DW:0]     idx;
   logic [PW-1:0]   pt;
   logic            fire;
   logic            last;
   logic [2*CW-1:0] prod;
   logic [CW-1:0]   x;
   logic [PW-1:0]   m;

   assign fire = bus.in_valid && bus.in_ready;
   assign last = (idx == (DW+1)'(N));
   assign prod = {{CW{1'b0}}, bus.ct_entry}
               * {{CW{1'b0}}, bus.sk_entry};
   assign x    = bus.ct_entry - acc;

   lwe_round #(
      .CW (CW),
      .PW (PW)
   ) u_round (
      .x (x),
      .m (m)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ACCUM;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ACCUM: if (fire && last) state_nxt = OUT;
         OUT:   if (bus.out_ready) state_nxt = ACCUM;
         default: state_nxt = ACCUM;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state == ACCUM) && !rst;
      bus.out_valid = (state == OUT);
      bus.plaintext = pt;
      bus.beat_idx  = idx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
         idx <= '0;
         pt  <= '0;
      end else if (fire) begin
         if (last) begin
            pt  <= m;
            acc <= '0;
            idx <= '0;
         end else begin
            acc <= acc + prod[CW-1:0];
            idx <= idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_decrypt.sv
// Randomized self-checking bench for decrypt against an arithmetic
// model m = round(p*x/q) mod p with x = b - sum(a_i*s_i) mod q.
module tb_decrypt;

   localparam int Q  = 1024;
   localparam int P  = 64;
   localparam int N  = 10;
   localparam int TO = 50;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_checks = 0;
   int n_errors = 0;

   decrypt_if bus ();

   decrypt dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int ref_m(input int a[N], input int s[N],
                                input int b);
      longint sum;
      longint x;
      sum = 0;
      for (int i = 0; i < N; i++) sum += longint'(a[i]) * s[i];
      x = ((b - sum) % Q + Q) % Q;
      return int'(((x * P + Q / 2) / Q) % P);
   endfunction

   // Present one beat; returns once it is accepted (#1 after edge).
   task automatic send_beat(input int a, input int s, output bit ok);
      int t;
      ok = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.ct_entry = a[9:0];
      bus.sk_entry = s[9:0];
      t = 0;
      while (!bus.in_ready && t < TO) begin
         @(negedge clk);
         t++;
      end
      if (t >= TO) begin
         check("beat_timeout", 0, 1);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      ok = 1'b1;
   endtask

   task automatic send_vec(input int a[N], input int s[N], input int b,
                           input int gap_max, input string tag);
      bit ok;
      int exp;
      exp = ref_m(a, s, b);
      for (int i = 0; i <= N; i++) begin
         repeat ($urandom_range(0, gap_max)) @(negedge clk);
         check({tag, "_idx"}, int'(bus.beat_idx), i);
         if (i < N) send_beat(a[i], s[i], ok);
         else       send_beat(b, $urandom_range(0, Q - 1), ok);
         if (!ok) return;
      end
      check({tag, "_ovalid"}, int'(bus.out_valid), 1);
      check({tag, "_m"}, int'(bus.plaintext), exp);
      check({tag, "_irdy"}, int'(bus.in_ready), 0);
   endtask

   task automatic take_out(input int hold, input string tag);
      int pt0;
      pt0 = int'(bus.plaintext);
      repeat (hold) begin
         @(negedge clk);
         bus.out_ready = 1'b0;
      end
      @(negedge clk);
      check({tag, "_hold_m"}, int'(bus.plaintext), pt0);
      check({tag, "_hold_ov"}, int'(bus.out_valid), 1);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check({tag, "_ov_drop"}, int'(bus.out_valid), 0);
      check({tag, "_irdy_up"}, int'(bus.in_ready), 1);
   endtask

   task automatic fill(output int a[N], output int s[N], input int av,
                       input int sv);
      for (int i = 0; i < N; i++) begin
         a[i] = av;
         s[i] = sv;
      end
   endtask

   initial begin
      int a[N];
      int s[N];
      bit ok;
      bus.in_valid  = 1'b0;
      bus.ct_entry  = '0;
      bus.sk_entry  = '0;
      bus.out_ready = 1'b0;

      #3;
      check("rst_irdy", int'(bus.in_ready), 0);
      check("rst_ov", int'(bus.out_valid), 0);
      check("rst_m", int'(bus.plaintext), 0);
      check("rst_idx", int'(bus.beat_idx), 0);
      #10 rst = 1'b0;

      fill(a, s, 3, 1);
      send_vec(a, s, 113, 0, "basic");
      check("basic_lit", int'(bus.plaintext), 5);
      // backpressure with in_valid held high
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.ct_entry = 10'd7;
         check("bp_irdy", int'(bus.in_ready), 0);
         check("bp_m", int'(bus.plaintext), 5);
         check("bp_idx", int'(bus.beat_idx), 0);
      end
      bus.in_valid = 1'b0;
      take_out(0, "bp");

      send_vec(a, s, 105, 0, "neg");
      check("neg_lit", int'(bus.plaintext), 5);
      take_out(1, "neg");

      fill(a, s, 1000, 1000);
      send_vec(a, s, 128, 0, "wrap");
      check("wrap_lit", int'(bus.plaintext), 32);
      take_out(0, "wrap");

      fill(a, s, 3, 1);
      send_vec(a, s, 21, 0, "edge63");
      check("edge63_lit", int'(bus.plaintext), 63);
      take_out(0, "edge63");
      send_vec(a, s, 22, 0, "edge0");
      check("edge0_lit", int'(bus.plaintext), 0);
      take_out(0, "edge0");

      // reset mid-vector
      for (int i = 0; i < 4; i++) send_beat(7, 9, ok);
      check("mid_idx4", int'(bus.beat_idx), 4);
      #3 rst = 1'b1;
      #1;
      check("mid_rst_irdy", int'(bus.in_ready), 0);
      check("mid_rst_idx", int'(bus.beat_idx), 0);
      #2 rst = 1'b0;
      send_vec(a, s, 113, 0, "after_rst");
      check("after_rst_lit", int'(bus.plaintext), 5);
      take_out(0, "after_rst");
      send_vec(a, s, 113, 3, "gaps");
      check("gaps_lit", int'(bus.plaintext), 5);

      // reset while holding a plaintext
      #3 rst = 1'b1;
      #1;
      check("out_rst_ov", int'(bus.out_valid), 0);
      check("out_rst_m", int'(bus.plaintext), 0);
      #2 rst = 1'b0;

      for (int v = 0; v < 20; v++) begin
         for (int i = 0; i < N; i++) begin
            a[i] = $urandom_range(0, Q - 1);
            s[i] = $urandom_range(0, Q - 1);
         end
         send_vec(a, s, $urandom_range(0, Q - 1), 2, "rand");
         take_out($urandom_range(0, 3), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/decrypt.md
Name: decrypt

Overview:
- LWE decryption datapath; the receive-side counterpart of the `encrypt` accumulator.
- Consumes one ciphertext vector as a stream of beats. Beats 0..DIMENSION-1 are a_i paired with secret-key entry s_i; beat DIMENSION is b.
- Computes x = b - sum(a_i*s_i) mod q, then rounds x to a plaintext m in [0, p).
- Sits between the ciphertext/key memories and the plaintext consumer, with valid/ready on both sides.

Parameters:
- PLAINTEXT_MODULUS, 64, p. Must be a power of two.
- PLAINTEXT_WIDTH, 6, log2(p).
- CIPHERTEXT_MODULUS, 1024, q. Must be a power of two, q > p.
- CIPHERTEXT_WIDTH, 10, log2(q).
- DIMENSION, 10, n = number of a/s pairs per ciphertext.
- DIM_WIDTH, 4, beat-counter width. Must satisfy 2^DIM_WIDTH > DIMENSION.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset. Asynchronous, active-high.
- in_valid  in  1  ciphertext beat valid.
- in_ready  out  1  block can accept a beat.
- ct_entry  in  CIPHERTEXT_WIDTH  a_i on beats 0..n-1; b on beat n.
- sk_entry  in  CIPHERTEXT_WIDTH  s_i on beats 0..n-1; ignored on beat n.
- out_valid  out  1  plaintext valid.
- out_ready  in  1  consumer accepts plaintext.
- plaintext  out  PLAINTEXT_WIDTH  decoded m.
- beat_idx  out  DIM_WIDTH+1  index of the next beat expected (debug/status).

Behaviour:
- Reset (asserted, async): state=ACCUM, acc=0, beat_idx=0, in_ready=0 while rst high, out_valid=0, plaintext=0.
- in_ready = (state==ACCUM) && !rst. It is registered-state driven and never combinationally dependent on in_valid.
- A beat is accepted when in_valid && in_ready on a rising clk edge.
- ACCUM, beat_idx < n, beat accepted:
  - acc <= (acc + ct_entry*sk_entry) mod q. The product is taken at full width and its low CIPHERTEXT_WIDTH bits are kept; the sum wraps mod q.
  - beat_idx++.
- ACCUM, beat_idx == n, beat accepted:
  - x = (ct_entry - acc) mod q, using CIPHERTEXT_WIDTH-bit wrap.
  - plaintext <= ((x + q/(2p)) >> (CIPHERTEXT_WIDTH-PLAINTEXT_WIDTH)) mod p. Round-half-up with wrap, so x near q decodes to 0.
  - state <= OUT, out_valid <= 1, acc <= 0, beat_idx <= 0.
  - Latency: out_valid rises on the edge that accepts b, visible the following cycle.
- OUT:
  - in_ready=0. plaintext and out_valid held stable until out_valid && out_ready.
  - On that handshake: out_valid <= 0, state <= ACCUM. The next vector may start on the following cycle, so minimum throughput is n+2 cycles per ciphertext.
- No idle gaps are required: in_valid may drop between beats, and acc/beat_idx simply hold.
- out_ready asserted while out_valid=0 has no effect.
- Reset mid-vector discards the partial accumulation. After release the next beat is treated as beat 0.
- Reset while in OUT drops the pending plaintext.
- No signed arithmetic anywhere; all values are unsigned residues mod q.

Decomposition:
- Shared package `lwe_pkg`:
  - default widths/moduli as localparams;
  - ROUND_OFFSET = q/(2p);
  - SHIFT = CIPHERTEXT_WIDTH-PLAINTEXT_WIDTH;
  - state enum {ACCUM, OUT}.
- Sub-module `lwe_round`: purely combinational x -> m (offset add, shift, truncate). It can be reused by future key-switch/bootstrap blocks.
- The top module holds the FSM, counter, accumulator and handshakes.

Test Plan (defaults q=1024, p=64, n=10, offset 8, shift 4):
- Basic decode:
  - Stimulus: all a_i=3, s_i=1 (acc=30), b=113 (m=5, e=+3).
  - Response: plaintext=5, out_valid the cycle after the b beat, in_ready=0 until out_ready.
- Negative noise:
  - Same a/s, b=105 (e=-5).
  - Response: plaintext=5.
- Accumulator wrap:
  - Stimulus: all a_i=1000, s_i=1000 (each product ≡576, acc=640), b=128.
  - Response: x=512, plaintext=32.
- Output wrap boundary:
  - acc=30. b=30+1015=1045 mod 1024=21 → x=1015 → plaintext=63.
  - b=30+1016 mod 1024=22 → x=1016 → plaintext=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid; assert in_valid throughout.
  - Response: plaintext stable, in_ready=0, no beat consumed. When out_ready=1 for one cycle, out_valid drops and in_ready rises next cycle.
- Reset mid-operation:
  - Stimulus: send 4 beats, pulse rst asynchronously (between edges), then send the full basic-decode vector.
  - Response: outputs clear immediately on rst; beat_idx=0; final plaintext=5. Also insert in_valid gaps between beats and check the same result.
